// File: rtl/bootrom_pkg.sv
// Shared types and default geometry for the boot ROM arbiter.
package bootrom_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RESP    = 2'd2
   } state_e;

   localparam int unsigned BOOTROM_ADDR_W = 17;
   localparam int unsigned BOOTROM_DATA_W = 32;
   localparam int unsigned BOOTROM_DEPTH  = 73728;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_vld_o
);

   // Walk the rotated request vector; the first hit locks out later ones.
   always_comb begin
      logic [IDX_W-1:0] sel;
      logic             hit;
      sel         = '0;
      hit         = 1'b0;
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         sel          = IDX_W'((32'(ptr_i) + off) % NREQ);
         hit          = !grant_vld_o && req_i[sel];
         grant_o[sel] = grant_o[sel] | hit;
         grant_idx_o  = hit ? sel : grant_idx_o;
         grant_vld_o  = grant_vld_o | hit;
      end
   end

endmodule

// File: rtl/bootrom_arbiter.sv
// Round-robin sharing of one me/oe boot ROM between NREQ read requesters,
// one transaction in flight, with an out-of-range error on the response.
module bootrom_arbiter
   import bootrom_pkg::*;
#(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ADDR_W = BOOTROM_ADDR_W,
   parameter int unsigned DATA_W = BOOTROM_DATA_W,
   parameter int unsigned DEPTH  = BOOTROM_DEPTH
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   output logic [NREQ-1:0]        resp_valid,
   input  logic [NREQ-1:0]        resp_ready,
   output logic [DATA_W-1:0]      resp_data,
   output logic                   resp_err,
   output logic                   rom_me,
   output logic                   rom_oe,
   output logic [ADDR_W-1:0]      rom_address,
   input  logic [DATA_W-1:0]      rom_q,
   output logic                   busy
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                resp_err_q, resp_err_d;

   logic [NREQ-1:0]     grant_oh;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_vld;
   logic [ADDR_W-1:0]   gnt_addr;
   logic                gnt_in_range;
   logic [IDX_W-1:0]    next_ptr;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant_oh),
      .grant_idx_o (grant_idx),
      .grant_vld_o (grant_vld)
   );

   assign gnt_addr     = req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign gnt_in_range = ({1'b0, gnt_addr} < DEPTH_C);
   assign next_ptr     = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);

   // State register and response holding registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         err_q       <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         err_q       <= err_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Next-state logic; rom_q is only looked at in CAPTURE, and not at all on an error.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      err_d       = err_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               owner_d = grant_idx;
               err_d   = !gnt_in_range;
               ptr_d   = next_ptr;
               state_d = CAPTURE;
            end else begin
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            resp_data_d = err_q ? '0 : rom_q;
            resp_err_d  = err_q;
            state_d     = RESP;
         end
         RESP: begin
            if (resp_ready[owner_q]) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // IDLE outputs follow the live grant and are forced low while reset is held.
   always_comb begin
      req_ready   = '0;
      rom_me      = 1'b0;
      rom_oe      = 1'b0;
      rom_address = '0;
      resp_valid  = '0;
      case (state_q)
         IDLE: begin
            if (reset_n && grant_vld) begin
               req_ready   = grant_oh;
               rom_me      = gnt_in_range;
               rom_address = gnt_addr;
            end else begin
               req_ready   = '0;
            end
         end
         CAPTURE: rom_oe = !err_q;
         RESP:    resp_valid[owner_q] = 1'b1;
         default: resp_valid = '0;
      endcase
   end

   assign resp_data = resp_data_q;
   assign resp_err  = resp_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Self-checking bench for bootrom_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_bootrom_arbiter;

   localparam int NREQ   = 2;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 73728;

   typedef struct {
      int                owner;
      logic [ADDR_W-1:0] addr;
      int                t;
   } txn_t;

   logic                   clock = 1'b0;
   logic                   reset_n;
   logic [NREQ-1:0]        req_valid, req_ready, resp_valid, resp_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0]      resp_data, rom_q, rom_dq;
   logic                   resp_err, rom_me, rom_oe, busy;
   logic [ADDR_W-1:0]      rom_address;
   logic                   float_z = 1'b0;
   int                     checks = 0;
   int                     errors = 0;

   bootrom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address), .rom_q(rom_q), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[16:1]} ^ 32'h0F1E_2D3C;
   endfunction

   // ROM macro model: registered read on me, output floats (X or Z) unless oe.
   always @(posedge clock) if (rom_me) rom_dq <= rom_word(rom_address);
   always @(negedge clock) float_z <= 1'($urandom_range(0, 1));
   assign rom_q = rom_oe ? rom_dq : (float_z ? {DATA_W{1'bz}} : {DATA_W{1'bx}});

   function automatic int exp_grant(input logic [NREQ-1:0] mask, input int ptr);
      int best = -1;
      int bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (mask[i] && ((i - ptr + NREQ) % NREQ) < bestd) begin
            bestd = (i - ptr + NREQ) % NREQ;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic apply_reset();
      reset_n = 1'b0; req_valid = '0; req_addr = '0; resp_ready = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = '1; req_addr = {17'h00005, 17'h00003}; resp_ready = '1;
      @(negedge clock); #1;
      checks++;
      if (req_ready !== 2'b00 || resp_valid !== 2'b00 || rom_me !== 1'b0 || rom_oe !== 1'b0 ||
          busy !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0 || rom_address !== 17'h0) begin
         errors++;
         $display("FAIL reset_state: ready=%b rv=%b me=%b oe=%b busy=%b data=%h err=%b addr=%h, want all 0",
                  req_ready, resp_valid, rom_me, rom_oe, busy, resp_data, resp_err, rom_address);
      end
   endtask

   task automatic test_single();
      apply_reset();
      resp_ready = '1; req_addr[0 +: ADDR_W] = 17'h00010; req_valid = 2'b01; #1;
      checks++;
      if (req_ready !== 2'b01 || rom_me !== 1'b1 || rom_oe !== 1'b0 || rom_address !== 17'h00010) begin
         errors++;
         $display("FAIL single_issue: ready=%b me=%b oe=%b addr=%h, want 01 1 0 00010", req_ready, rom_me, rom_oe, rom_address);
      end
      @(negedge clock); req_valid = '0; #1;
      checks++;
      if (rom_me !== 1'b0 || rom_oe !== 1'b1 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
         errors++;
         $display("FAIL single_capture: me=%b oe=%b rv=%b ready=%b, want 0 1 00 00", rom_me, rom_oe, resp_valid, req_ready);
      end
      @(negedge clock); #1;
      checks++;
      if (resp_valid !== 2'b01 || resp_data !== rom_word(17'h00010) || resp_err !== 1'b0 || rom_oe !== 1'b0 || rom_me !== 1'b0) begin
         errors++;
         $display("FAIL single_resp: rv=%b data=%h err=%b oe=%b me=%b, want 01 %h 0 0 0",
                  resp_valid, resp_data, resp_err, rom_oe, rom_me, rom_word(17'h00010));
      end
      @(negedge clock); #1;
      checks++;
      if (busy !== 1'b0 || resp_valid !== 2'b00) begin
         errors++;
         $display("FAIL single_idle: busy=%b rv=%b, want 0 00", busy, resp_valid);
      end
   endtask

   task automatic test_out_of_range();
      logic [ADDR_W-1:0] a;
      logic              e_err;
      logic [DATA_W-1:0] e_data;
      resp_ready = '1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         case (k)
            0:       a = 17'd73728;
            1:       a = 17'd73727;
            default: a = 17'h1FFFF;
         endcase
         e_err  = (int'(a) >= DEPTH);
         e_data = e_err ? '0 : rom_word(a);
         req_addr[ADDR_W +: ADDR_W] = a; req_valid = 2'b10; #1;
         checks++;
         if (req_ready !== 2'b10 || rom_me !== !e_err) begin
            errors++;
            $display("FAIL oor_issue addr=%0d: ready=%b me=%b, want 10 %b", a, req_ready, rom_me, !e_err);
         end
         @(negedge clock); req_valid = '0; #1;
         checks++;
         if (rom_me !== 1'b0 || rom_oe !== !e_err) begin
            errors++;
            $display("FAIL oor_capture addr=%0d: me=%b oe=%b, want 0 %b", a, rom_me, rom_oe, !e_err);
         end
         @(negedge clock); #1;
         checks++;
         if (resp_valid !== 2'b10 || resp_err !== e_err || resp_data !== e_data) begin
            errors++;
            $display("FAIL oor_resp addr=%0d: rv=%b err=%b data=%h, want 10 %b %h", a, resp_valid, resp_err, resp_data, e_err, e_data);
         end
      end
   endtask

   task automatic test_contention();
      int                mptr = 0;
      int                g;
      int                cur_owner = -1;
      int                nresp = 0;
      logic [ADDR_W-1:0] cur_addr = '0;
      logic [NREQ-1:0]   want;
      apply_reset();
      req_addr = {17'h00200, 17'h00100}; req_valid = '1; resp_ready = '1;
      for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
         #1;
         if (req_ready !== 2'b00) begin
            g = exp_grant(req_valid, mptr);
            want = '0; want[g] = 1'b1;
            checks++;
            if (req_ready !== want) begin
               errors++;
               $display("FAIL contention_grant: ready=%b, want %b", req_ready, want);
            end
            cur_owner = g; cur_addr = req_addr[g*ADDR_W +: ADDR_W]; mptr = (g + 1) % NREQ;
         end
         if (resp_valid !== 2'b00) begin
            want = '0; want[cur_owner] = 1'b1;
            checks++;
            if (resp_valid !== want || resp_data !== rom_word(cur_addr) || resp_err !== 1'b0) begin
               errors++;
               $display("FAIL contention_resp: rv=%b data=%h err=%b, want %b %h 0", resp_valid, resp_data, resp_err, want, rom_word(cur_addr));
            end
            nresp++;
         end
         @(negedge clock);
      end
      checks++;
      if (nresp != 4) begin
         errors++;
         $display("FAIL contention_count: responses=%0d, want 4 within 40 cycles", nresp);
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      resp_ready = '0; req_addr[ADDR_W +: ADDR_W] = 17'h0ABCD; req_valid = 2'b10; #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL bp_issue: ready=%b, want 10", req_ready);
      end
      @(negedge clock); req_valid = 2'b01; req_addr[0 +: ADDR_W] = 17'h00042; #1;
      checks++;
      if (req_ready !== 2'b00 || rom_oe !== 1'b1) begin
         errors++;
         $display("FAIL bp_capture: ready=%b oe=%b, want 00 1", req_ready, rom_oe);
      end
      for (int s = 0; s < 5; s++) begin
         @(negedge clock); #1;
         checks++;
         if (resp_valid !== 2'b10 || resp_data !== rom_word(17'h0ABCD) || req_ready !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall%0d: rv=%b data=%h ready=%b busy=%b, want 10 %h 00 1", s, resp_valid, resp_data, req_ready, busy, rom_word(17'h0ABCD));
         end
      end
      @(negedge clock); resp_ready = 2'b10; #1;
      checks++;
      if (resp_valid !== 2'b10 || req_ready !== 2'b00) begin
         errors++;
         $display("FAIL bp_release: rv=%b ready=%b, want 10 00", resp_valid, req_ready);
      end
      @(negedge clock); resp_ready = '1; #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== 2'b01 || resp_valid !== 2'b00) begin
         errors++;
         $display("FAIL bp_reidle: busy=%b ready=%b rv=%b, want 0 01 00", busy, req_ready, resp_valid);
      end
      @(negedge clock); req_valid = '0;
      @(negedge clock); #1;
      checks++;
      if (resp_valid !== 2'b01 || resp_data !== rom_word(17'h00042)) begin
         errors++;
         $display("FAIL bp_next: rv=%b data=%h, want 01 %h", resp_valid, resp_data, rom_word(17'h00042));
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      resp_ready = '1; req_addr[0 +: ADDR_W] = 17'h00777; req_valid = 2'b01; #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rmid_issue: ready=%b, want 01", req_ready);
      end
      @(negedge clock); req_valid = '0; #1;
      checks++;
      if (rom_oe !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_capture: oe=%b busy=%b, want 1 1", rom_oe, busy);
      end
      reset_n = 1'b0; #1;
      checks++;
      if (req_ready !== 2'b00 || resp_valid !== 2'b00 || rom_me !== 1'b0 || rom_oe !== 1'b0 || busy !== 1'b0 ||
          resp_data !== 32'h0 || resp_err !== 1'b0 || rom_address !== 17'h0) begin
         errors++;
         $display("FAIL rmid_async: ready=%b rv=%b me=%b oe=%b busy=%b data=%h err=%b addr=%h, want all 0",
                  req_ready, resp_valid, rom_me, rom_oe, busy, resp_data, resp_err, rom_address);
      end
      @(negedge clock); reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_stale%0d: rv=%b busy=%b, want 00 0", k, resp_valid, busy);
         end
         @(negedge clock);
      end
      req_addr = {17'h00321, 17'h00123}; req_valid = '1; #1;
      checks++;
      if (req_ready !== 2'b01 || rom_address !== 17'h00123) begin
         errors++;
         $display("FAIL rmid_ptr: ready=%b addr=%h, want 01 00123", req_ready, rom_address);
      end
      @(negedge clock); req_valid = '0;
      @(negedge clock); #1;
      checks++;
      if (resp_valid !== 2'b01 || resp_data !== rom_word(17'h00123)) begin
         errors++;
         $display("FAIL rmid_resp: rv=%b data=%h, want 01 %h", resp_valid, resp_data, rom_word(17'h00123));
      end
   endtask

   task automatic test_random();
      txn_t              q[$];
      txn_t              t;
      int                mptr = 0;
      int                g;
      int                clear_g = -1;
      logic [ADDR_W-1:0] a, ga;
      logic [NREQ-1:0]   exp_ready, exp_rv;
      logic              exp_me, exp_oe, exp_err;
      logic [DATA_W-1:0] exp_data;
      apply_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clock);
         if (clear_g >= 0) req_valid[clear_g] = 1'b0;
         clear_g = -1;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 3))
                  0:       a = ADDR_W'($urandom_range(0, DEPTH - 1));
                  1:       a = ADDR_W'(DEPTH - 1);
                  2:       a = ADDR_W'(DEPTH);
                  default: a = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
               endcase
               req_addr[i*ADDR_W +: ADDR_W] = a;
               req_valid[i] = 1'b1;
            end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
            resp_ready[i] = ($urandom_range(0, 3) != 0);
         end
         #1;
         g = (q.size() == 0) ? exp_grant(req_valid, mptr) : -1;
         exp_ready = '0; exp_me = 1'b0; ga = '0;
         if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ga = req_addr[g*ADDR_W +: ADDR_W];
            exp_me = (int'(ga) < DEPTH);
         end
         exp_oe = (q.size() != 0) && (q[0].t == cyc - 1) && (int'(q[0].addr) < DEPTH);
         exp_rv = '0; exp_err = 1'b0; exp_data = '0;
         if (q.size() != 0 && cyc >= q[0].t + 2) begin
            exp_rv[q[0].owner] = 1'b1;
            exp_err  = (int'(q[0].addr) >= DEPTH);
            exp_data = exp_err ? '0 : rom_word(q[0].addr);
         end
         checks++;
         if (req_ready !== exp_ready || rom_me !== exp_me || rom_address !== ga) begin
            errors++;
            $display("FAIL rnd_request c%0d: ready=%b me=%b addr=%h, want %b %b %h", cyc, req_ready, rom_me, rom_address, exp_ready, exp_me, ga);
         end
         checks++;
         if (rom_oe !== exp_oe || busy !== (q.size() != 0)) begin
            errors++;
            $display("FAIL rnd_strobe c%0d: oe=%b busy=%b, want %b %b", cyc, rom_oe, busy, exp_oe, (q.size() != 0));
         end
         checks++;
         if (resp_valid !== exp_rv || (exp_rv != '0 && (resp_data !== exp_data || resp_err !== exp_err))) begin
            errors++;
            $display("FAIL rnd_response c%0d: rv=%b data=%h err=%b, want %b %h %b", cyc, resp_valid, resp_data, resp_err, exp_rv, exp_data, exp_err);
         end
         checks++;
         if ((^resp_data) === 1'bx) begin
            errors++;
            $display("FAIL rnd_data_known c%0d: data=%h, want no X", cyc, resp_data);
         end
         if (exp_rv != '0 && resp_ready[q[0].owner]) void'(q.pop_front());
         if (g >= 0) begin
            t.owner = g; t.addr = ga; t.t = cyc;
            q.push_back(t);
            mptr = (g + 1) % NREQ;
            clear_g = g;
         end
      end
      @(negedge clock);
      req_valid = '0; resp_ready = '1;
      repeat (4) @(negedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || resp_valid !== 2'b00) begin
         errors++;
         $display("FAIL rnd_drain: busy=%b rv=%b, want 0 00", busy, resp_valid);
      end
   endtask

   initial begin
      reset_n = 1'b0; req_valid = '0; req_addr = '0; resp_ready = '0;
      test_reset();
      test_single();
      test_out_of_range();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
